// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared GPR geometry constants for the five-stage pipeline.
// Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;
   localparam int GPR_NREG = 32;   // architectural GPR count
   localparam int GPR_CNT_W = 2;   // pending-writer counter width
   localparam int GPR_AW = 5;      // GPR address width
   localparam int RA_REG = 1;      // bl link destination
endpackage
`default_nettype wire

// File: rtl/sb_reg_counter.sv
`default_nettype none
// ============================================================================
// Module      : sb_reg_counter
// Description : Saturating up/down pending-writer counter for one GPR.
// Revision    : 1.0  initial release
// ============================================================================
module sb_reg_counter
   import cpu_pkg::*;
#(
   parameter int CNT_W = GPR_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             sat_err
);

   localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};

   // An issue into a full counter is only an error when it is not cancelled
   // by a flush and not balanced by a same-cycle retire.
   assign sat_err = inc & ~dec & ~clr & (cnt == C_MAX);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !dec && (cnt != C_MAX)) begin
         cnt <= cnt + 1'b1;
      end else if (dec && !inc && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Per-GPR pending-write scoreboard and decode stall controller.
// Revision    : 1.0  initial release
// ============================================================================
module hazard_scoreboard
   import cpu_pkg::*;
#(
   parameter int NREG   = GPR_NREG,
   parameter int CNT_W  = GPR_CNT_W,
   parameter int STAT_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic              rs1_used,
   input  logic [GPR_AW-1:0] rs1_addr,
   input  logic              rs2_used,
   input  logic [GPR_AW-1:0] rs2_addr,
   input  logic              issue_fire,
   input  logic              issue_we,
   input  logic [GPR_AW-1:0] issue_dest,
   input  logic              retire_fire,
   input  logic [GPR_AW-1:0] retire_dest,
   input  logic              flush,
   output logic              stall,
   output logic [NREG-1:0]   busy_mask,
   output logic              overflow,
   output logic [STAT_W-1:0] stall_cycles
);

   logic [NREG-1:0] sat_vec;
   logic            rs1_busy;
   logic            rs2_busy;

   assign busy_mask[0] = 1'b0;
   assign sat_vec[0]   = 1'b0;

   // r0 is hard-wired zero, so only registers 1..NREG-1 get a counter.
   generate
      for (genvar i = 1; i < NREG; i++) begin : g_reg
         logic [CNT_W-1:0] cnt;
         logic             inc;
         logic             dec;

         assign inc = issue_fire & issue_we & (issue_dest == GPR_AW'(i));
         assign dec = retire_fire & (retire_dest == GPR_AW'(i));

         sb_reg_counter #(
            .CNT_W (CNT_W)
         ) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .inc     (inc),
            .dec     (dec),
            .clr     (flush),
            .cnt     (cnt),
            .sat_err (sat_vec[i])
         );

         assign busy_mask[i] = |cnt;
      end
   endgenerate

   // busy_mask[0] is constant zero, so reading r0 never stalls.
   assign rs1_busy = rs1_used & busy_mask[rs1_addr];
   assign rs2_busy = rs2_used & busy_mask[rs2_addr];
   assign stall    = id_valid & (rs1_busy | rs2_busy);

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow     <= 1'b0;
         stall_cycles <= '0;
      end else begin
         if (|sat_vec) begin
            overflow <= 1'b1;
         end
         if (stall) begin
            stall_cycles <= stall_cycles + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed and randomized checks of hazard_scoreboard.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid, rs1_used, rs2_used;
   logic [4:0]  rs1_addr, rs2_addr;
   logic        issue_fire, issue_we, retire_fire, flush;
   logic [4:0]  issue_dest, retire_dest;
   logic        stall, overflow;
   logic [31:0] busy_mask, stall_cycles;

   int tests = 0;
   int fails = 0;

   // Reference state: how many writers are in flight per register.
   int          m_cnt [32];
   bit          m_ovf;
   int unsigned m_stat;

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .clk          (clk),
      .reset        (reset),
      .id_valid     (id_valid),
      .rs1_used     (rs1_used),
      .rs1_addr     (rs1_addr),
      .rs2_used     (rs2_used),
      .rs2_addr     (rs2_addr),
      .issue_fire   (issue_fire),
      .issue_we     (issue_we),
      .issue_dest   (issue_dest),
      .retire_fire  (retire_fire),
      .retire_dest  (retire_dest),
      .flush        (flush),
      .stall        (stall),
      .busy_mask    (busy_mask),
      .overflow     (overflow),
      .stall_cycles (stall_cycles)
   );

   function automatic bit m_stall();
      bit a, b;
      a = rs1_used && (rs1_addr != 0) && (m_cnt[rs1_addr] != 0);
      b = rs2_used && (rs2_addr != 0) && (m_cnt[rs2_addr] != 0);
      return id_valid && (a || b);
   endfunction

   function automatic logic [31:0] m_busy();
      logic [31:0] m;
      m = '0;
      for (int i = 1; i < 32; i++) m[i] = (m_cnt[i] != 0);
      return m;
   endfunction

   task automatic clear_inputs();
      id_valid = 0; rs1_used = 0; rs2_used = 0; rs1_addr = 0; rs2_addr = 0;
      issue_fire = 0; issue_we = 0; issue_dest = 0;
      retire_fire = 0; retire_dest = 0; flush = 0;
   endtask

   // Advance one clock edge, evolving the reference model alongside.
   task automatic tick();
      int nxt [32];
      bit st, iss, ret;
      st  = m_stall();
      nxt = m_cnt;
      if (reset) begin
         for (int i = 0; i < 32; i++) nxt[i] = 0;
      end else if (flush) begin
         for (int i = 0; i < 32; i++) nxt[i] = 0;
      end else begin
         for (int i = 1; i < 32; i++) begin
            iss = issue_fire && issue_we && (issue_dest == i);
            ret = retire_fire && (retire_dest == i);
            if (iss && !ret) begin
               if (nxt[i] == 3) m_ovf = 1;
               else nxt[i] = nxt[i] + 1;
            end else if (ret && !iss && nxt[i] > 0) begin
               nxt[i] = nxt[i] - 1;
            end
         end
      end
      @(posedge clk);
      #1;
      m_cnt = nxt;
      if (reset) begin
         m_ovf  = 0;
         m_stat = 0;
      end else if (st) begin
         m_stat = m_stat + 1;
      end
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1;
      tick();
      reset = 0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      tests++; if (busy_mask !== 32'h0) begin fails++; $display("FAIL reset_busy got %h want %h", busy_mask, 32'h0); end
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
      tests++; if (stall_cycles !== 32'd0) begin fails++; $display("FAIL reset_stat got %0d want 0", stall_cycles); end
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", overflow); end
      id_valid = 1; rs1_used = 1; rs1_addr = 5;
      #1;
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL idle_decode_stall got %b want 0", stall); end
   endtask

   task automatic test_issue_retire();
      do_reset();
      id_valid = 1; issue_fire = 1; issue_we = 1; issue_dest = 5;
      tick();
      issue_fire = 0; rs1_used = 1; rs1_addr = 5;
      @(negedge clk);
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL dep_stall got %b want 1", stall); end
      tests++; if (busy_mask !== 32'h20) begin fails++; $display("FAIL dep_busy got %h want %h", busy_mask, 32'h20); end
      tick();
      tick();
      retire_fire = 1; retire_dest = 5;
      @(negedge clk);
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL no_bypass_stall got %b want 1", stall); end
      tick();
      retire_fire = 0;
      @(negedge clk);
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL post_retire_stall got %b want 0", stall); end
      tests++; if (stall_cycles !== 32'd3) begin fails++; $display("FAIL stall_count got %0d want 3", stall_cycles); end
   endtask

   task automatic test_r0();
      do_reset();
      issue_fire = 1; issue_we = 1; issue_dest = 0;
      tick();
      issue_fire = 0; id_valid = 1; rs1_used = 1; rs1_addr = 0; rs2_used = 1; rs2_addr = 0;
      @(negedge clk);
      tests++; if (busy_mask !== 32'h0) begin fails++; $display("FAIL r0_busy got %h want 0", busy_mask); end
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL r0_stall got %b want 0", stall); end
   endtask

   task automatic test_overflow();
      do_reset();
      issue_fire = 1; issue_we = 1; issue_dest = 7;
      repeat (3) tick();
      issue_fire = 0;
      @(negedge clk);
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_at_three got %b want 0", overflow); end
      issue_fire = 1;
      tick();
      @(negedge clk);
      tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set got %b want 1", overflow); end
      retire_fire = 1; retire_dest = 7;
      tick();
      issue_fire = 0;
      tick();
      tick();
      retire_fire = 0;
      @(negedge clk);
      tests++; if (busy_mask !== 32'h80) begin fails++; $display("FAIL sat_hold_busy got %h want %h", busy_mask, 32'h80); end
      retire_fire = 1;
      tick();
      retire_fire = 0;
      @(negedge clk);
      tests++; if (busy_mask !== 32'h0) begin fails++; $display("FAIL drain_busy got %h want 0", busy_mask); end
      tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b want 1", overflow); end
   endtask

   task automatic test_flush();
      do_reset();
      issue_fire = 1; issue_we = 1; issue_dest = 9;
      repeat (2) tick();
      flush = 1;
      tick();
      flush = 0; issue_fire = 0;
      @(negedge clk);
      tests++; if (busy_mask !== 32'h0) begin fails++; $display("FAIL flush_busy got %h want 0", busy_mask); end
      retire_fire = 1; retire_dest = 9;
      tick();
      retire_fire = 0;
      @(negedge clk);
      tests++; if (busy_mask !== 32'h0) begin fails++; $display("FAIL stale_retire_busy got %h want 0", busy_mask); end
      issue_fire = 1; issue_dest = 9;
      tick();
      issue_fire = 0;
      retire_fire = 1;
      tick();
      retire_fire = 0;
      @(negedge clk);
      tests++; if (busy_mask !== 32'h0) begin fails++; $display("FAIL one_issue_one_retire got %h want 0", busy_mask); end
      issue_fire = 1; issue_dest = 12; reset = 1;
      tick();
      reset = 0; issue_fire = 0;
      @(negedge clk);
      tests++; if (busy_mask !== 32'h0) begin fails++; $display("FAIL midreset_busy got %h want 0", busy_mask); end
   endtask

   task automatic test_rs_used();
      do_reset();
      issue_fire = 1; issue_we = 1; issue_dest = 4;
      tick();
      issue_fire = 0; id_valid = 1; rs2_addr = 4; rs2_used = 0;
      @(negedge clk);
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rs2_unused got %b want 0", stall); end
      rs2_used = 1;
      #1;
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL rs2_used got %b want 1", stall); end
      id_valid = 0;
      #1;
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL no_valid got %b want 0", stall); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         id_valid = 1'($urandom_range(0, 3) != 0);
         rs1_used = 1'($urandom);
         rs2_used = 1'($urandom);
         rs1_addr = 5'($urandom_range(0, 11));
         rs2_addr = 5'($urandom_range(0, 11));
         issue_we = 1'($urandom_range(0, 3) != 0);
         issue_dest = 5'($urandom_range(0, 11));
         issue_fire = 1'($urandom_range(0, 2) != 0) & ~m_stall();
         retire_fire = 1'($urandom);
         retire_dest = 5'($urandom_range(0, 11));
         flush = 1'($urandom_range(0, 40) == 0);
         @(negedge clk);
         tests++; if (stall !== m_stall()) begin fails++; $display("FAIL rand_stall cyc %0d got %b want %b", c, stall, m_stall()); end
         tests++; if (busy_mask !== m_busy()) begin fails++; $display("FAIL rand_busy cyc %0d got %h want %h", c, busy_mask, m_busy()); end
         tests++; if (overflow !== m_ovf) begin fails++; $display("FAIL rand_ovf cyc %0d got %b want %b", c, overflow, m_ovf); end
         tests++; if (stall_cycles !== m_stat) begin fails++; $display("FAIL rand_stat cyc %0d got %0d want %0d", c, stall_cycles, m_stat); end
         tick();
      end
   endtask

   initial begin
      clear_inputs();
      reset = 1;
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_ovf = 0;
      m_stat = 0;
      test_reset();
      test_issue_retire();
      test_r0();
      test_overflow();
      test_flush();
      test_rs_used();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
